// File: rtl/fp_mul_pipe_if.sv
// fp_mul_pipe_if -- handshake bundle for the pipelined floating-point multiplier.
//
// Operand side : in_valid / in_ready handshake carrying in_a, in_b.
// Result side  : out_valid / out_ready handshake carrying out_result, out_flags.
// out_flags    : {invalid, overflow, underflow, inexact}.
//
// Modports
//   master : the producer/consumer environment (drives operands and out_ready)
//   slave  : the multiplier itself
interface fp_mul_pipe_if #(
  parameter int EXP_W = 3,
  parameter int MAN_W = 4
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [3:0]   out_flags;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe -- three-stage pipelined multiplier for a small IEEE-754-style
// format {sign, exp[EXP_W], man[MAN_W]} with round-to-nearest-even,
// subnormals, infinities and NaN.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : fp_mul_pipe_if.slave
//            in_valid/in_ready/in_a/in_b         operand handshake
//            out_valid/out_ready/out_result/out_flags  result handshake
//            out_flags = {invalid, overflow, underflow, inexact}
//
// Stages: p1 decode/classify, p2 significand multiply + exponent sum,
// p3 normalise/round/pack. The whole pipe advances together whenever the
// output register is empty or being drained.
module fp_mul_pipe #(
  parameter int EXP_W = 3,
  parameter int MAN_W = 4
) (
  input logic          clk,
  input logic          rst_n,
  fp_mul_pipe_if.slave bus
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int SW   = MAN_W + 1;      // significand incl. hidden bit
  localparam int PW   = 2 * MAN_W + 2;  // exact product width
  localparam int EW   = EXP_W + 6;      // internal signed exponent width
  localparam int RW   = EXP_W + MAN_W + 3;

  localparam logic signed [EW-1:0] BIAS_S   = EW'(BIAS);
  localparam logic signed [EW-1:0] ONE_S    = EW'(1);
  localparam logic signed [EW-1:0] EMAX_S   = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] MSHIFT_S = EW'(2 * MAN_W);
  localparam logic [EXP_W-1:0]     EXP_ONES = '1;

  typedef struct packed {
    logic                 sign;
    logic                 zero;
    logic                 inf;
    logic                 nan;
    logic [SW-1:0]        sig;
    logic signed [EW-1:0] ex;   // unbiased effective exponent
  } opnd_t;

  function automatic opnd_t decode(input logic [W-1:0] x);
    opnd_t            d;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    logic [EXP_W-1:0] e_eff;
    e      = x[W-2 -: EXP_W];
    m      = x[MAN_W-1:0];
    d.sign = x[W-1];
    d.zero = (e == '0) && (m == '0);
    d.inf  = (e == EXP_ONES) && (m == '0);
    d.nan  = (e == EXP_ONES) && (m != '0);
    d.sig  = {e != '0, m};
    // Subnormals share the exponent of the smallest normal.
    e_eff  = (e == '0) ? EXP_W'(1) : e;
    d.ex   = $signed(EW'(e_eff)) - BIAS_S;
    return d;
  endfunction

  // Normalise the exact product, denormalise if tiny, round to nearest even
  // and saturate to infinity. Returns {ovf, unf, inx, exp_field, man_field}.
  function automatic logic [RW-1:0] norm_round(input logic [PW-1:0] prod,
                                               input logic signed [EW-1:0] esum);
    logic [PW-1:0]           norm;
    logic [PW-1:0]           shifted;
    logic signed [EW-1:0]    eb;
    logic signed [EW-1:0]    sh;
    logic signed [EW-1:0]    exp_field;
    logic signed [EW-1:0]    exp_r;
    logic [EW+MAN_W-1:0]     pk;
    logic [MAN_W-1:0]        man;
    logic [MAN_W-1:0]        man_r;
    logic [EXP_W-1:0]        exp_out;
    logic                    tiny, lost, guard, sticky, rnd, ovf, inx;
    int                      k;
    k = 0;
    for (int i = 0; i < PW; i++) begin
      if (prod[i]) k = i;
    end
    norm      = prod << (PW - 1 - k);
    eb        = esum + EW'(k) - MSHIFT_S + BIAS_S;
    tiny      = (eb < ONE_S);
    shifted   = norm;
    lost      = 1'b0;
    exp_field = eb;
    if (tiny) begin
      // Shift into the subnormal grid; anything pushed off the end is sticky.
      sh        = ONE_S - eb;
      shifted   = norm >> sh;
      lost      = ((shifted << sh) != norm);
      exp_field = '0;
    end
    man    = shifted[PW-2 -: MAN_W];
    guard  = shifted[MAN_W];
    sticky = (|shifted[MAN_W-1:0]) | lost;
    rnd    = guard & (sticky | man[0]);
    // A carry out of the mantissa bumps the exponent, which also turns the
    // largest subnormal into the minimum normal.
    pk      = {exp_field, man} + {{(EW+MAN_W-1){1'b0}}, rnd};
    exp_r   = pk[EW+MAN_W-1 -: EW];
    man_r   = pk[MAN_W-1:0];
    inx     = guard | sticky;
    ovf     = (exp_r >= EMAX_S);
    exp_out = exp_r[EXP_W-1:0];
    if (ovf) begin
      exp_out = EXP_ONES;
      man_r   = '0;
      inx     = 1'b1;
    end
    return {ovf, tiny & inx, inx, exp_out, man_r};
  endfunction

  logic adv;

  opnd_t                a_p1, b_p1;
  logic                 vld_p1;

  logic                 sign_p2, nan_p2, inf_p2, zero_p2;
  logic [PW-1:0]        prod_p2;
  logic signed [EW-1:0] esum_p2;
  logic                 vld_p2;

  logic [W-1:0]         result_p3;
  logic [3:0]           flags_p3;
  logic                 vld_p3;

  logic [W-1:0]         res_c;
  logic [3:0]           flg_c;
  logic [RW-1:0]        nr_c;

  assign adv            = !vld_p3 || bus.out_ready;
  assign bus.in_ready   = adv;
  assign bus.out_valid  = vld_p3;
  assign bus.out_result = result_p3;
  assign bus.out_flags  = flags_p3;

  // ---- stage p1: decode / classify ----
  always_ff @(posedge clk) begin
    if (adv) begin
      a_p1 <= decode(bus.in_a);
      b_p1 <= decode(bus.in_b);
    end
  end

  // ---- stage p2: significand multiply, exponent sum, special class ----
  always_ff @(posedge clk) begin
    if (adv) begin
      sign_p2 <= a_p1.sign ^ b_p1.sign;
      nan_p2  <= a_p1.nan | b_p1.nan | (a_p1.inf & b_p1.zero) | (a_p1.zero & b_p1.inf);
      inf_p2  <= a_p1.inf | b_p1.inf;
      zero_p2 <= a_p1.zero | b_p1.zero;
      prod_p2 <= PW'(a_p1.sig) * PW'(b_p1.sig);
      esum_p2 <= a_p1.ex + b_p1.ex;
    end
  end

  // ---- stage p3: normalise / round / pack ----
  always_comb begin
    res_c = '0;
    flg_c = '0;
    nr_c  = norm_round(prod_p2, esum_p2);
    if (nan_p2) begin
      res_c = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
      flg_c = 4'b1000;
    end else if (inf_p2) begin
      res_c = {sign_p2, EXP_ONES, {MAN_W{1'b0}}};
    end else if (zero_p2) begin
      res_c = {sign_p2, {(W-1){1'b0}}};
    end else begin
      res_c = {sign_p2, nr_c[EXP_W+MAN_W-1:0]};
      flg_c = {1'b0, nr_c[RW-1 -: 3]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      vld_p3    <= 1'b0;
      result_p3 <= '0;
      flags_p3  <= '0;
    end else if (adv) begin
      vld_p1    <= bus.in_valid;
      vld_p2    <= vld_p1;
      vld_p3    <= vld_p2;
      result_p3 <= res_c;
      flags_p3  <= flg_c;
    end
  end

endmodule
